// File: rtl/coin_start_pkg.sv
// Shared types and default frame counts for the coin/start auto-credit sequencer.
package coin_start_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCoin,
    StGap,
    StStart,
    StRelease
  } seq_state_t;

  localparam int unsigned DefCoinFrames  = 4;
  localparam int unsigned DefGapFrames   = 8;
  localparam int unsigned DefStartFrames = 4;
  localparam int unsigned DefFrameCntW   = 6;

endpackage

// File: rtl/coin_start_sequencer_edge_rise.sv
// Rising-edge detector on a registered copy of the input. The first cycle after reset
// never reports an edge, so a level already high at reset release is not an edge.
module edge_rise #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev_q;
  logic             armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= sig;
      armed_q <= 1'b1;
    end
  end

  assign rise = armed_q ? (sig & ~prev_q) : '0;

endmodule

// File: rtl/coin_start_sequencer.sv
// Auto-credit sequencer: one start press injects a frame-timed coin pulse, a gap,
// then a matching start pulse. With auto-credit disabled it is a registered pass-through.
module coin_start_sequencer
  import coin_start_pkg::*;
#(
  parameter int unsigned COIN_FRAMES  = DefCoinFrames,
  parameter int unsigned GAP_FRAMES   = DefGapFrames,
  parameter int unsigned START_FRAMES = DefStartFrames,
  parameter int unsigned FRAME_CNT_W  = DefFrameCntW
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       vblank,
  input  logic       enable,
  input  logic [1:0] btn_start,
  input  logic       btn_coin,
  output logic       coin_out,
  output logic [1:0] start_out,
  output logic       busy,
  output logic [7:0] credits
);

  localparam logic [FRAME_CNT_W-1:0] CoinLast  = FRAME_CNT_W'(COIN_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] GapLast   = FRAME_CNT_W'(GAP_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] StartLast = FRAME_CNT_W'(START_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] CntOne    = FRAME_CNT_W'(1);

  seq_state_t             state_q;
  logic [FRAME_CNT_W-1:0] cnt_q;
  logic                   sel_q;
  logic                   tick_q;
  logic                   vblank_rise;
  logic [1:0]             start_rise;

  edge_rise #(
    .WIDTH(1)
  ) u_vblank_edge (
    .clk  (clk_sys),
    .rst_n(reset_n),
    .sig  (vblank),
    .rise (vblank_rise)
  );

  edge_rise #(
    .WIDTH(2)
  ) u_start_edge (
    .clk  (clk_sys),
    .rst_n(reset_n),
    .sig  (btn_start),
    .rise (start_rise)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      tick_q    <= 1'b0;
      coin_out  <= 1'b0;
      start_out <= 2'b00;
      busy      <= 1'b0;
      credits   <= 8'd0;
    end else begin
      // Frame tick is registered once more, so it is acted on one edge after detection.
      tick_q <= vblank_rise;
      unique case (state_q)
        StIdle: begin
          cnt_q     <= '0;
          coin_out  <= btn_coin;
          start_out <= enable ? 2'b00 : btn_start;
          if (enable && (start_rise != 2'b00)) begin
            state_q   <= StCoin;
            sel_q     <= ~start_rise[0];  // player 1 wins a simultaneous press
            coin_out  <= 1'b1;
            start_out <= 2'b00;
            busy      <= 1'b1;
            if (credits != 8'hFF) credits <= credits + 8'd1;
          end
        end
        StCoin: begin
          if (tick_q) begin
            if (cnt_q == CoinLast) begin
              state_q  <= StGap;
              cnt_q    <= '0;
              coin_out <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
        end
        StGap: begin
          if (tick_q) begin
            if (cnt_q == GapLast) begin
              state_q   <= StStart;
              cnt_q     <= '0;
              start_out <= sel_q ? 2'b10 : 2'b01;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
        end
        StStart: begin
          if (tick_q) begin
            if (cnt_q == StartLast) begin
              state_q   <= StRelease;
              cnt_q     <= '0;
              start_out <= 2'b00;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
        end
        StRelease: begin
          if (btn_start == 2'b00) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          cnt_q     <= '0;
          coin_out  <= 1'b0;
          start_out <= 2'b00;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/coin_start_sequencer.md
# coin_start_sequencer

Auto-credit sequencer between the player-input merge logic (keyboard/joystick start buttons) and the arcade core's coin/select inputs. A single start press injects a timed coin pulse, then a matching start pulse, each measured in video frames from the core's vblank. This gives the core the coin-then-start handshake that real cabinet hardware expects. When auto-credit is disabled, the block is a registered pass-through.

## Interface
Parameters:
- COIN_FRAMES, 4: frame ticks coin_out is held high; legal range 1..2^FRAME_CNT_W.
- GAP_FRAMES, 8: frame ticks between the coin pulse and the start pulse; legal range 1..2^FRAME_CNT_W.
- START_FRAMES, 4: frame ticks start_out is held high; legal range 1..2^FRAME_CNT_W.
- FRAME_CNT_W, 6: width of the frame counter.

Ports:
- clk_sys  in  1  system clock; all logic runs on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vblank  in  1  core vblank, synchronous to clk_sys; each rising edge is one frame tick.
- enable  in  1  auto-credit enable; sampled only in IDLE.
- btn_start  in  2  start request levels, active high; bit 0 is player 1, bit 1 is player 2.
- btn_coin  in  1  manual coin level, active high.
- coin_out  out  1  coin to the core, active high.
- start_out  out  2  start/select to the core, active high.
- busy  out  1  high in every state except IDLE.
- credits  out  8  count of auto-injected coins; saturates at 255.

## Operation
- States: IDLE, COIN, GAP, START, RELEASE.
- Frame tick: registered rising-edge detect on vblank.
- Start edge: registered rising-edge detect per bit of btn_start.
- Frame counter: cleared on every state entry; incremented on each tick. A state with duration N exits on the tick that finds count == N-1, so it exits on the Nth tick after entry.
- IDLE, enable=0: coin_out follows btn_coin and start_out follows btn_start, both registered. No sequence ever starts.
- IDLE, enable=1: coin_out still follows btn_coin. start_out stays 0.
  - Any start edge latches the player in sel, increments credits (saturating), and moves to COIN.
  - If both edges arrive in the same cycle, player 1 wins (sel=0).
- COIN: coin_out=1, start_out=0. Exits to GAP after COIN_FRAMES ticks.
- GAP: all outputs 0. Exits to START after GAP_FRAMES ticks.
- START: start_out[sel]=1, the other bit 0, coin_out=0. Exits to RELEASE after START_FRAMES ticks.
- RELEASE: all outputs 0. Returns to IDLE in the cycle after btn_start == 2'b00 is sampled.
- Outside IDLE:
  - btn_coin and new start edges are ignored.
  - A change of enable has no effect; the sequence always completes.
- Reset: state goes to IDLE; coin_out, start_out, busy, credits, the counter and all edge-detect registers go to 0 immediately and asynchronously. This applies mid-sequence too. After release, a button that is already held does not produce an edge.

## Timing
- All outputs are registered.
- Pass-through latency: 1 cycle from input to output.
- Start edge sampled at clock edge k: state = COIN, coin_out = 1, busy = 1 and credits incremented, all visible after edge k.
- vblank rising edge sampled at edge k: the tick is acted on at edge k+1.
- Output transitions land on the clock edge after the terminating tick was registered.
- A vblank that is already high at reset release is not a tick.

## Structure
- Package coin_start_pkg holds:
  - typedef seq_state_t, the enum of the 5 states;
  - the default frame-count localparams.
- One sub-module, edge_rise: a parameterised-width registered rising-edge detector with async active-low reset. It is instantiated for vblank (width 1) and btn_start (width 2).
- The FSM, frame counter and output registers live in the top module.

## Test plan
- enable=0; pulse btn_start=2'b10 and btn_coin. Outputs mirror the inputs one cycle later; busy stays 0; credits stays 0.
- enable=1, default params, press P1 start. coin_out is high for 4 ticks, then low for 8 ticks, then start_out=2'b01 for 4 ticks. credits reads 1.
- enable=1, both starts rise in the same cycle. start_out=2'b01 only. A P2 press during GAP changes nothing.
- Hold start through the START phase. The block stays in RELEASE with busy=1 until release, then returns to IDLE one cycle later. No second coin is injected.
- Assert reset_n=0 mid-COIN. All outputs and credits read 0 immediately. After release with vblank held high, no tick occurs until the next rising edge.
- Run 260 sequences. credits saturates at 255.
